// File: rtl/truth_table_checker.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_checker
//  Description : Sweeps a 3-input unit under test through all eight input
//                vectors, holds each for HOLD_CYCLES cycles, samples the
//                response on the last held cycle and counts mismatches
//                against the expected function (~b & ~c) | (a & ~b).
//                Optional feature macro: TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
//                adds first_fail_vld / first_fail_idx capture of the first
//                mismatching vector of each sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_checker #(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
  ,
  output logic       first_fail_vld,
  output logic [2:0] first_fail_idx
`endif
);

  // Expected response indexed by {a,b,c}: 1 for vectors 0, 4 and 5.
  localparam logic [7:0] c_exp_table = 8'h31;
  localparam logic [7:0] c_last_hold = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_idx;
  logic [7:0] r_hold;
  logic       w_sample;
  logic       w_mismatch;
  logic       w_last_vec;

  // The response is only trusted on the final cycle of each held vector,
  // giving the unit under test HOLD_CYCLES-1 cycles to settle.
  assign w_sample   = (r_state == ST_DRIVE) && (r_hold == c_last_hold);
  assign w_mismatch = w_sample && (y_in != c_exp_table[r_idx]);
  assign w_last_vec = (r_idx == 3'd7);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and status/stimulus outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    a_out       = 1'b0;
    b_out       = 1'b0;
    c_out       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        busy                  = 1'b1;
        {a_out, b_out, c_out} = r_idx;
        if (w_sample && w_last_vec) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Vector index, hold counter, mismatch count and pass flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= 3'd0;
      r_hold  <= 8'd0;
      err_cnt <= 4'd0;
      pass    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx   <= 3'd0;
            r_hold  <= 8'd0;
            err_cnt <= 4'd0;
            pass    <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (w_sample) begin
            r_hold <= 8'd0;
            if (w_mismatch) begin
              err_cnt <= err_cnt + 4'd1;
            end
            // Index parks at 7 on the last vector; it never wraps mid-sweep.
            if (!w_last_vec) begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_hold <= r_hold + 8'd1;
          end
        end
        ST_DONE: begin
          // err_cnt already includes the vector-7 comparison here.
          pass  <= (err_cnt == 4'd0);
          r_idx <= 3'd0;
        end
        default: begin
          r_idx  <= 3'd0;
          r_hold <= 8'd0;
        end
      endcase
    end
  end

`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
  // Sticky capture of the first mismatching vector within a sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_fail_vld <= 1'b0;
      first_fail_idx <= 3'd0;
    end else if ((r_state == ST_IDLE) && start) begin
      first_fail_vld <= 1'b0;
      first_fail_idx <= 3'd0;
    end else if (w_mismatch && !first_fail_vld) begin
      first_fail_vld <= 1'b1;
      first_fail_idx <= r_idx;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_truth_table_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_truth_table_checker
//  Description : Self-checking bench for truth_table_checker. A modelled
//                unit under test answers from an 8-entry response table;
//                expected counts come from evaluating the boolean function.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_checker;

  localparam int H = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       y_in;
  logic       a_out, b_out, c_out;
  logic       busy, done, pass;
  logic [3:0] err_cnt;
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
  logic       first_fail_vld;
  logic [2:0] first_fail_idx;
`endif

  logic [7:0] resp = 8'h00;
  int total = 0;
  int bad   = 0;

  truth_table_checker #(.HOLD_CYCLES(H)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .y_in    (y_in),
    .a_out   (a_out),
    .b_out   (b_out),
    .c_out   (c_out),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt)
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
    ,
    .first_fail_vld (first_fail_vld),
    .first_fail_idx (first_fail_idx)
`endif
  );

  always #5 clk = ~clk;

  // Modelled unit under test: response looked up from the current stimulus.
  assign y_in = resp[{a_out, b_out, c_out}];

  typedef struct {
    logic [7:0] resp;
    int         exp_err;
    bit         exp_pass;
    int         exp_ff;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit golden(input int i);
    bit a, b, c;
    a = (i / 4) % 2 == 1;
    b = (i / 2) % 2 == 1;
    c = i % 2 == 1;
    return (!b && !c) || (a && !b);
  endfunction

  function automatic int ref_errs(input logic [7:0] r);
    int n = 0;
    for (int i = 0; i < 8; i++) if (r[i] != golden(i)) n++;
    return n;
  endfunction

  function automatic int ref_first(input logic [7:0] r);
    for (int i = 0; i < 8; i++) if (r[i] != golden(i)) return i;
    return 0;
  endfunction

  // One full sweep started at cycle 0, checked cycle by cycle up to 8H+3.
  task automatic sweep(input logic [7:0] r, input int exp_err, input bit exp_pass,
                       input int exp_ff, input bit repulse, input string tag);
    int busy_bad = 0, stim_bad = 0, done_cnt = 0, done_at = -1, clr_bad = 0;
    int eb, es;
    resp = r;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 8 * H + 3; cyc++) begin
      @(negedge clk);
      start = repulse && (cyc == 5 || cyc == 80);
      eb = (cyc >= 1 && cyc <= 8 * H) ? 1 : 0;
      es = eb ? (cyc - 1) / H : 0;
      if (int'(busy) != eb) busy_bad++;
      if (int'({a_out, b_out, c_out}) != es) stim_bad++;
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
      if (cyc == 1 && (pass !== 1'b0 || err_cnt !== 4'd0)) clr_bad++;
    end
    start = 1'b0;
    chk({tag, "_busy_bad_cycles"}, busy_bad, 0);
    chk({tag, "_stim_bad_cycles"}, stim_bad, 0);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_done_cycle"}, done_at, 8 * H + 1);
    chk({tag, "_clear_on_start"}, clr_bad, 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), exp_err);
    chk({tag, "_pass"}, int'(pass), int'(exp_pass));
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
    chk({tag, "_ff_vld"}, int'(first_fail_vld), exp_pass ? 0 : 1);
    chk({tag, "_ff_idx"}, int'(first_fail_idx), exp_ff);
`endif
  endtask

  initial begin
    logic [7:0] r;
    int guard;
    tbl[0] = '{8'h31, 0, 1'b1, 0};  // golden responder
    tbl[1] = '{8'h00, 3, 1'b0, 0};  // stuck at 0
    tbl[2] = '{8'hFF, 5, 1'b0, 1};  // stuck at 1
    tbl[3] = '{8'hCE, 8, 1'b0, 0};  // inverted golden

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_stim", int'({a_out, b_out, c_out}), 0);
    chk("reset_err_cnt", int'(err_cnt), 0);
    chk("reset_pass", int'(pass), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      sweep(tbl[i].resp, tbl[i].exp_err, tbl[i].exp_pass, tbl[i].exp_ff, 1'b0,
            $sformatf("tbl%0d", i));
    end

    sweep(8'h00, 3, 1'b0, 0, 1'b1, "repulse");

    // Reset in the middle of vector 3.
    resp = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(busy && {a_out, b_out, c_out} == 3'd3) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("midrst_reach_idx3", guard < 100 ? 1 : 0, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_stim", int'({a_out, b_out, c_out}), 0);
    chk("midrst_err_cnt", int'(err_cnt), 0);
    chk("midrst_pass", int'(pass), 0);
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
    chk("midrst_ff_vld", int'(first_fail_vld), 0);
`endif
    sweep(8'h31, 0, 1'b1, 0, 1'b0, "after_rst");

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_vs_start_busy", int'(busy), 0);
    chk("rst_vs_start_pass", int'(pass), 0);
    @(negedge clk);
    chk("rst_vs_start_busy_later", int'(busy), 0);

    // Random responders against the boolean reference.
    for (int k = 0; k < 6; k++) begin
      r = 8'($urandom);
      sweep(r, ref_errs(r), ref_errs(r) == 0, ref_first(r), 1'b0,
            $sformatf("rand%0d_%02h", k, r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
